// File: rtl/operand_entry_alu.sv
// operand_entry_alu: turns three switches, two op switches and two bouncy
// pushbuttons into an (A, B, op) operand set for the ALU. The user loads the
// operands one at a time and the set is handed over with a valid/ready handshake.

// ---------------------------------------------------------------------------
// btn_conditioner: two-flop synchronizer, counter debouncer and a registered
// one-cycle pulse on each debounced rising edge. The synchronized level must
// disagree with the debounced level for DEBOUNCE_CYCLES consecutive cycles
// before the debounced level follows it.
// ---------------------------------------------------------------------------
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic press_o
);

  // Counter value at which the last disagreeing cycle is seen.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             deb_q, deb_d;
  logic             deb_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q;

  // Debounce decision: any agreement restarts the count; a full run of
  // disagreement lets the debounced level take the synchronized level.
  always_comb begin
    cnt_d = cnt_q;
    deb_d = deb_q;
    if (sync2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      deb_d = sync2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer, debounce state and press pulse registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
      press_q    <= 1'b0;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      cnt_q      <= cnt_d;
      // Only the 0->1 transition of the debounced level produces a pulse.
      press_q    <= deb_q & ~deb_prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// ---------------------------------------------------------------------------
// operand_entry_alu: entry FSM A -> B -> OP -> ISSUE with clear/abort.
// ---------------------------------------------------------------------------
module operand_entry_alu #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       CLK_50,
  input  logic       rst,
  input  logic [2:0] sw,
  input  logic [1:0] op_sw,
  input  logic       btn_next,
  input  logic       btn_clear,
  input  logic       alu_ready,
  output logic [2:0] A,
  output logic [2:0] B,
  output logic [1:0] op,
  output logic       alu_en,
  output logic [1:0] stage,
  output logic [7:0] issue_count
);

  // Stage encoding doubles as the stage output seen by the display.
  typedef enum logic [1:0] {
    S_A     = 2'd0,
    S_B     = 2'd1,
    S_OP    = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  localparam int NUM_BTN = 2;
  localparam int BTN_NEXT  = 0;
  localparam int BTN_CLEAR = 1;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] btn_press;
  logic               next_press;
  logic               clear_press;

  state_t     state_q, state_d;
  logic [2:0] a_q, a_d;
  logic [2:0] b_q, b_d;
  logic [1:0] op_q, op_d;
  logic       en_q, en_d;
  logic [7:0] cnt_q, cnt_d;

  assign btn_raw[BTN_NEXT]  = btn_next;
  assign btn_raw[BTN_CLEAR] = btn_clear;

  // Both buttons get identical conditioning.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
      btn_conditioner #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_cond (
        .clk_i  (CLK_50),
        .rst_i  (rst),
        .raw_i  (btn_raw[gi]),
        .press_o(btn_press[gi])
      );
    end
  endgenerate

  assign next_press  = btn_press[BTN_NEXT];
  assign clear_press = btn_press[BTN_CLEAR];

  // Next-state and load logic; clear overrides every other event.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    en_d    = en_q;
    cnt_d   = cnt_q;
    if (clear_press) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      op_d    = '0;
      en_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_A: begin
          if (next_press) begin
            a_d     = sw;
            state_d = S_B;
          end
        end
        S_B: begin
          if (next_press) begin
            b_d     = sw;
            state_d = S_OP;
          end
        end
        S_OP: begin
          if (next_press) begin
            op_d    = op_sw;
            en_d    = 1'b1;
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          // Operands are frozen here; further next presses are ignored.
          if (alu_ready) begin
            en_d    = 1'b0;
            cnt_d   = cnt_q + 8'd1;
            state_d = S_A;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  // State and operand registers.
  always_ff @(posedge CLK_50) begin
    if (rst) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      en_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      en_q    <= en_d;
      cnt_q   <= cnt_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign op          = op_q;
  assign alu_en      = en_q;
  assign stage       = state_q;
  assign issue_count = cnt_q;

endmodule

// File: tb/tb_operand_entry_alu.sv
// Self-checking bench for operand_entry_alu with a short debounce window.
// A cycle-level reference model built from the behavioural rules is compared
// against every output after every clock edge, plus directed checks.
module tb_operand_entry_alu;

  localparam int D = 4;

  logic       CLK_50 = 1'b0;
  logic       rst;
  logic [2:0] sw;
  logic [1:0] op_sw;
  logic       btn_next;
  logic       btn_clear;
  logic       alu_ready;
  logic [2:0] A;
  logic [2:0] B;
  logic [1:0] op;
  logic       alu_en;
  logic [1:0] stage;
  logic [7:0] issue_count;

  operand_entry_alu #(
    .DEBOUNCE_CYCLES(D),
    .CNT_W          (3)
  ) dut (
    .CLK_50     (CLK_50),
    .rst        (rst),
    .sw         (sw),
    .op_sw      (op_sw),
    .btn_next   (btn_next),
    .btn_clear  (btn_clear),
    .alu_ready  (alu_ready),
    .A          (A),
    .B          (B),
    .op         (op),
    .alu_en     (alu_en),
    .stage      (stage),
    .issue_count(issue_count)
  );

  always #10 CLK_50 = ~CLK_50;

  int n_checks = 0;
  int n_pass   = 0;
  int en_cycles = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Per button: raw samples from the previous two edges, debounced level,
  // length of the current disagreement run, debounced level after the last
  // three edges (a debounced rise acts on the FSM two edges later).
  bit         m_raw1 [2];
  bit         m_raw2 [2];
  bit         m_deb  [2];
  int         m_run  [2];
  bit         m_deb1 [2];
  bit         m_deb2 [2];
  bit         m_deb3 [2];
  int         m_stage;
  int         m_a, m_b, m_op, m_count;

  task automatic model_edge();
    bit nxt, clr, raw, seen;
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_raw1[i] = 0; m_raw2[i] = 0; m_deb[i] = 0; m_run[i] = 0;
        m_deb1[i] = 0; m_deb2[i] = 0; m_deb3[i] = 0;
      end
      m_stage = 0; m_a = 0; m_b = 0; m_op = 0; m_count = 0;
      return;
    end
    nxt = m_deb2[0] && !m_deb3[0];
    clr = m_deb2[1] && !m_deb3[1];
    if (clr) begin
      m_stage = 0; m_a = 0; m_b = 0; m_op = 0;
    end else begin
      case (m_stage)
        0: if (nxt) begin m_a = int'(sw); m_stage = 1; end
        1: if (nxt) begin m_b = int'(sw); m_stage = 2; end
        2: if (nxt) begin m_op = int'(op_sw); m_stage = 3; end
        default: if (alu_ready) begin
          m_count = (m_count + 1) % 256;
          m_stage = 0;
          $display("issue %0d: A=%0d B=%0d op=%0d", m_count, m_a, m_b, m_op);
        end
      endcase
    end
    for (int i = 0; i < 2; i++) begin
      raw  = (i == 0) ? btn_next : btn_clear;
      seen = m_raw2[i];
      m_raw2[i] = m_raw1[i];
      m_raw1[i] = raw;
      if (seen != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == D) begin
          m_deb[i] = seen;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
      m_deb3[i] = m_deb2[i];
      m_deb2[i] = m_deb1[i];
      m_deb1[i] = m_deb[i];
    end
  endtask

  function automatic logic [18:0] model_vec();
    logic [2:0] a3, b3;
    logic [1:0] o2, s2;
    logic [7:0] c8;
    a3 = 3'(m_a); b3 = 3'(m_b); o2 = 2'(m_op); s2 = 2'(m_stage); c8 = 8'(m_count);
    return {a3, b3, o2, (m_stage == 3), s2, c8};
  endfunction

  // One clock edge: update the model, compare every output.
  task automatic step();
    @(posedge CLK_50);
    #1;
    model_edge();
    check("outs", {13'd0, A, B, op, alu_en, stage, issue_count}, {13'd0, model_vec()});
    if (alu_en) en_cycles++;
  endtask

  task automatic press(input int which);
    if (which == 0) btn_next = 1'b1; else btn_clear = 1'b1;
    repeat (D + 6) step();
    if (which == 0) btn_next = 1'b0; else btn_clear = 1'b0;
    repeat (D + 6) step();
  endtask

  // Press next and measure edges from the first sampling edge to the stage move.
  task automatic press_next_timed(input logic [2:0] s, input logic [1:0] o, input string tag);
    int lat;
    logic [1:0] st0;
    sw = s; op_sw = o; st0 = stage; lat = -1;
    btn_next = 1'b1;
    for (int k = 0; k < D + 8; k++) begin
      step();
      if (lat < 0 && stage != st0) lat = k;
    end
    check(tag, lat, D + 3);
    btn_next = 1'b0;
    repeat (D + 6) step();
  endtask

  initial begin
    rst = 1'b1; sw = '0; op_sw = '0; btn_next = 1'b0; btn_clear = 1'b0; alu_ready = 1'b1;
    repeat (3) step();
    check("reset_outs", {A, B, op, alu_en, stage, issue_count}, 19'd0);
    rst = 1'b0;

    // Basic entry with an always-ready consumer.
    en_cycles = 0;
    press_next_timed(3'd5, 2'd0, "lat_a");
    check("stage_b", stage, 2'd1);
    press_next_timed(3'd3, 2'd0, "lat_b");
    check("stage_op", stage, 2'd2);
    press_next_timed(3'd0, 2'd2, "lat_op");
    check("t1_stage", stage, 2'd0);
    check("t1_a", A, 3'd5);
    check("t1_b", B, 3'd3);
    check("t1_op", op, 2'd2);
    check("t1_en_cycles", en_cycles, 1);
    check("t1_count", issue_count, 8'd1);

    // Bouncy press: 1-0-1-0 then held; one advance only.
    sw = 3'd4;
    for (int k = 0; k < 4; k++) begin
      btn_next = (k % 2 == 0);
      step();
    end
    btn_next = 1'b1;
    repeat (20) step();
    btn_next = 1'b0;
    repeat (D + 6) step();
    check("bounce_stage", stage, 2'd1);
    check("bounce_a", A, 3'd4);

    // Stalled consumer: alu_en must stay up 11 cycles with operands frozen.
    alu_ready = 1'b0;
    press_next_timed(3'd2, 2'd0, "lat_b2");
    op_sw = 2'd1;
    btn_next = 1'b1;
    en_cycles = 0;
    for (int k = 0; k < 20 && !alu_en; k++) step();
    check("t3_entered", stage, 2'd3);
    btn_next = 1'b0;
    for (int k = 0; k < 10; k++) begin
      sw = 3'($urandom); op_sw = 2'($urandom);
      step();
    end
    alu_ready = 1'b1;
    step();
    check("t3_en_cycles", en_cycles, 11);
    check("t3_hold", {A, B, op}, {3'd4, 3'd2, 2'd1});
    check("t3_count", issue_count, 8'd2);
    repeat (D + 6) step();

    // A full next press during a stalled issue is ignored.
    alu_ready = 1'b0;
    press(0); press(0); press(0);
    check("t3b_issue", stage, 2'd3);
    press(0);
    check("t3b_ignored", stage, 2'd3);
    alu_ready = 1'b1;
    step();
    check("t3b_count", issue_count, 8'd3);

    // Clear in S_OP, then clear together with next in S_B.
    press_next_timed(3'd7, 2'd0, "lat_a7");
    press_next_timed(3'd6, 2'd0, "lat_b6");
    press(1);
    check("clr_outs", {A, B, op, alu_en, stage}, 11'd0);
    press(0);
    btn_next = 1'b1; btn_clear = 1'b1;
    repeat (D + 6) step();
    btn_next = 1'b0; btn_clear = 1'b0;
    repeat (D + 6) step();
    check("clr_wins", stage, 2'd0);
    check("clr_count", issue_count, 8'd3);

    // 256 complete entries from reset wrap the counter.
    rst = 1'b1; step(); rst = 1'b0;
    alu_ready = 1'b1;
    for (int e = 0; e < 256; e++) begin
      sw = 3'($urandom); op_sw = 2'($urandom);
      press(0); press(0); press(0);
      if (e == 254) check("count_255", issue_count, 8'd255);
    end
    check("count_wrap", issue_count, 8'd0);

    // Reset while stalled in S_ISSUE.
    alu_ready = 1'b0;
    sw = 3'd7; op_sw = 2'd3;
    press(0); press(0); press(0);
    check("pre_rst_issue", stage, 2'd3);
    rst = 1'b1;
    step();
    check("rst_in_issue", {A, B, op, alu_en, stage, issue_count}, 19'd0);
    rst = 1'b0;
    alu_ready = 1'b1;

    // Button held through reset release.
    btn_next = 1'b1; sw = 3'd1;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    press_next_timed(3'd1, 2'd0, "lat_after_rst");
    check("held_one_adv", stage, 2'd1);

    // Random stimulus against the model.
    for (int c = 0; c < 3000; c++) begin
      sw = 3'($urandom); op_sw = 2'($urandom);
      alu_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) btn_next = ~btn_next;
      if ($urandom_range(0, 40) == 0) btn_clear = ~btn_clear;
      rst = ($urandom_range(0, 700) == 0);
      step();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
